// File: rtl/spm_mul_pipe.sv
// ----------------------------------------------------------------------------
// spm_mul_pipe
//   Multiply stage of the SpMV channel array. Each lane multiplies a matrix
//   value by a vector value. The row ID, lane-valid mask and end-of-row flag
//   travel with the product and have the same latency. Flow control is
//   valid/ready. The pipeline depth and the data widths are set by parameters.
//
//   Pipeline: S0 is the operand register. The product is formed between S0
//   and S1. S1..S{MUL_STAGES} are plain registers that synthesis may retime.
//   The outputs come from the last stage. A bundle accepted at cycle t shows
//   out_valid at t+MUL_STAGES+1 when there is no backpressure.
//
// Parameters
//   SPM_ELE_W   width of value, vector and product (product truncated)
//   ROW_ID_W    width of the row ID for each lane
//   CHAN_NUM    number of parallel lanes
//   MUL_STAGES  number of product registers after the operand register
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   in_valid / in_ready           input handshake
//   in_lane_mask, in_row_last     per-lane present / last-of-row flags
//   in_val, in_vec                packed operands, lane i at [i*W +: W]
//   in_row_id                     packed row IDs
//   out_valid / out_ready         output handshake
//   out_lane_mask, out_prod,
//   out_row_id, out_row_last      delayed bundle fields
//
// Optional feature (macro SPM_MUL_PIPE_PERF_EN)
//   Adds perf_beats (counts out_valid & out_ready) and perf_stall (counts
//   out_valid & !out_ready). Both counters saturate and both are cleared by
//   rst. The datapath is identical with or without the macro.
// ----------------------------------------------------------------------------
module spm_mul_pipe #(
    parameter int SPM_ELE_W  = 32,
    parameter int ROW_ID_W   = 32,
    parameter int CHAN_NUM   = 16,
    parameter int MUL_STAGES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHAN_NUM-1:0]            in_lane_mask,
    input  logic [CHAN_NUM*SPM_ELE_W-1:0]  in_val,
    input  logic [CHAN_NUM*SPM_ELE_W-1:0]  in_vec,
    input  logic [CHAN_NUM*ROW_ID_W-1:0]   in_row_id,
    input  logic [CHAN_NUM-1:0]            in_row_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHAN_NUM-1:0]            out_lane_mask,
    output logic [CHAN_NUM*SPM_ELE_W-1:0]  out_prod,
    output logic [CHAN_NUM*ROW_ID_W-1:0]   out_row_id,
    output logic [CHAN_NUM-1:0]            out_row_last
`ifdef SPM_MUL_PIPE_PERF_EN
    ,
    output logic [31:0]                    perf_beats,
    output logic [31:0]                    perf_stall
`endif
);

    localparam int DW = CHAN_NUM * SPM_ELE_W;
    localparam int IW = CHAN_NUM * ROW_ID_W;

    // Operand register (S0)
    logic                s0_valid_q, s0_valid_d;
    logic [CHAN_NUM-1:0] s0_mask_q,  s0_mask_d;
    logic [DW-1:0]       s0_val_q,   s0_val_d;
    logic [DW-1:0]       s0_vec_q,   s0_vec_d;
    logic [IW-1:0]       s0_id_q,    s0_id_d;
    logic [CHAN_NUM-1:0] s0_last_q,  s0_last_d;

    // Product stages (S1..S{MUL_STAGES})
    logic                st_valid_q [1:MUL_STAGES];
    logic                st_valid_d [1:MUL_STAGES];
    logic [CHAN_NUM-1:0] st_mask_q  [1:MUL_STAGES];
    logic [CHAN_NUM-1:0] st_mask_d  [1:MUL_STAGES];
    logic [DW-1:0]       st_prod_q  [1:MUL_STAGES];
    logic [DW-1:0]       st_prod_d  [1:MUL_STAGES];
    logic [IW-1:0]       st_id_q    [1:MUL_STAGES];
    logic [IW-1:0]       st_id_d    [1:MUL_STAGES];
    logic [CHAN_NUM-1:0] st_last_q  [1:MUL_STAGES];
    logic [CHAN_NUM-1:0] st_last_d  [1:MUL_STAGES];

    logic                advance;
    logic [DW-1:0]       mul_prod;
    logic [CHAN_NUM-1:0] mul_last;

    // The pipe moves as one unit. A bubble in the last stage never blocks it.
    assign advance  = !st_valid_q[MUL_STAGES] || out_ready;
    assign in_ready = advance;

    // Per-lane multiply. The lane mask gates the product and the row-last
    // flag, so the downstream accumulator sees zeros on lanes that are absent.
    // The row ID passes through without gating.
    genvar gi;
    generate
        for (gi = 0; gi < CHAN_NUM; gi++) begin : g_lane
            assign mul_prod[gi*SPM_ELE_W +: SPM_ELE_W] = s0_mask_q[gi]
                ? s0_val_q[gi*SPM_ELE_W +: SPM_ELE_W] * s0_vec_q[gi*SPM_ELE_W +: SPM_ELE_W]
                : '0;
            assign mul_last[gi] = s0_last_q[gi] & s0_mask_q[gi];
        end
    endgenerate

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_mask_d  = s0_mask_q;
        s0_val_d   = s0_val_q;
        s0_vec_d   = s0_vec_q;
        s0_id_d    = s0_id_q;
        s0_last_d  = s0_last_q;
        st_valid_d = st_valid_q;
        st_mask_d  = st_mask_q;
        st_prod_d  = st_prod_q;
        st_id_d    = st_id_q;
        st_last_d  = st_last_q;
        if (advance) begin
            s0_valid_d    = in_valid;
            s0_mask_d     = in_lane_mask;
            s0_val_d      = in_val;
            s0_vec_d      = in_vec;
            s0_id_d       = in_row_id;
            s0_last_d     = in_row_last;
            st_valid_d[1] = s0_valid_q;
            st_mask_d[1]  = s0_mask_q;
            st_prod_d[1]  = mul_prod;
            st_id_d[1]    = s0_id_q;
            st_last_d[1]  = mul_last;
            for (int k = 2; k <= MUL_STAGES; k++) begin
                st_valid_d[k] = st_valid_q[k-1];
                st_mask_d[k]  = st_mask_q[k-1];
                st_prod_d[k]  = st_prod_q[k-1];
                st_id_d[k]    = st_id_q[k-1];
                st_last_d[k]  = st_last_q[k-1];
            end
        end
    end

    // The data registers are cleared along with the valid bits, so the
    // outputs read zero straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_mask_q  <= '0;
            s0_val_q   <= '0;
            s0_vec_q   <= '0;
            s0_id_q    <= '0;
            s0_last_q  <= '0;
            for (int k = 1; k <= MUL_STAGES; k++) begin
                st_valid_q[k] <= 1'b0;
                st_mask_q[k]  <= '0;
                st_prod_q[k]  <= '0;
                st_id_q[k]    <= '0;
                st_last_q[k]  <= '0;
            end
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_mask_q  <= s0_mask_d;
            s0_val_q   <= s0_val_d;
            s0_vec_q   <= s0_vec_d;
            s0_id_q    <= s0_id_d;
            s0_last_q  <= s0_last_d;
            st_valid_q <= st_valid_d;
            st_mask_q  <= st_mask_d;
            st_prod_q  <= st_prod_d;
            st_id_q    <= st_id_d;
            st_last_q  <= st_last_d;
        end
    end

    assign out_valid     = st_valid_q[MUL_STAGES];
    assign out_lane_mask = st_mask_q[MUL_STAGES];
    assign out_prod      = st_prod_q[MUL_STAGES];
    assign out_row_id    = st_id_q[MUL_STAGES];
    assign out_row_last  = st_last_q[MUL_STAGES];

`ifdef SPM_MUL_PIPE_PERF_EN
    logic [31:0] perf_beats_q, perf_beats_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_beats_d = perf_beats_q;
        perf_stall_d = perf_stall_q;
        if (out_valid && out_ready && (perf_beats_q != 32'hFFFF_FFFF)) begin
            perf_beats_d = perf_beats_q + 32'd1;
        end
        if (out_valid && !out_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_beats_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_beats_q <= perf_beats_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_beats = perf_beats_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_spm_mul_pipe.sv
// ----------------------------------------------------------------------------
// tb_spm_mul_pipe
//   Directed and random stimulus for spm_mul_pipe (4 lanes, 4 product
//   stages). Each accepted input bundle pushes its expected output onto a
//   queue. Each cycle with out_valid high compares the outputs against the
//   head of the queue, and an output handshake pops that entry.
// ----------------------------------------------------------------------------
module tb_spm_mul_pipe;

    localparam int W = 32;
    localparam int C = 4;
    localparam int S = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [C-1:0]     in_lane_mask;
    logic [C*W-1:0]   in_val;
    logic [C*W-1:0]   in_vec;
    logic [C*W-1:0]   in_row_id;
    logic [C-1:0]     in_row_last;
    logic             out_valid;
    logic             out_ready;
    logic [C-1:0]     out_lane_mask;
    logic [C*W-1:0]   out_prod;
    logic [C*W-1:0]   out_row_id;
    logic [C-1:0]     out_row_last;
`ifdef SPM_MUL_PIPE_PERF_EN
    logic [31:0]      perf_beats;
    logic [31:0]      perf_stall;
`endif

    spm_mul_pipe #(
        .SPM_ELE_W (W),
        .ROW_ID_W  (W),
        .CHAN_NUM  (C),
        .MUL_STAGES(S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lane_mask (in_lane_mask),
        .in_val       (in_val),
        .in_vec       (in_vec),
        .in_row_id    (in_row_id),
        .in_row_last  (in_row_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_lane_mask(out_lane_mask),
        .out_prod     (out_prod),
        .out_row_id   (out_row_id),
        .out_row_last (out_row_last)
`ifdef SPM_MUL_PIPE_PERF_EN
        ,
        .perf_beats   (perf_beats),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [C-1:0]   mask;
        logic [C*W-1:0] prod;
        logic [C*W-1:0] id;
        logic [C-1:0]   last;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   pop_cnt   = 0;
    int   first_pop = -1;
    int   last_pop  = -1;
    int   mdl_beats = 0;
    int   mdl_stall = 0;

    task automatic chk(input string tag, input logic [C*W-1:0] obs, input logic [C*W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    function automatic exp_t model(input logic [C-1:0] m, input logic [C*W-1:0] v,
                                   input logic [C*W-1:0] x, input logic [C*W-1:0] id,
                                   input logic [C-1:0] l);
        exp_t e;
        logic [2*W-1:0] full;
        e.mask = m;
        e.id   = id;
        e.prod = '0;
        e.last = '0;
        for (int i = 0; i < C; i++) begin
            full = {32'd0, v[i*W +: W]} * {32'd0, x[i*W +: W]};
            if (m[i]) begin
                e.prod[i*W +: W] = full[W-1:0];
                e.last[i]        = l[i];
            end
        end
        return e;
    endfunction

    // One clock: sample and score at the negedge, then return 1 time unit
    // after the posedge so the caller can drive the next inputs.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            chk("in_ready", 128'(in_ready), 128'((!out_valid) || out_ready));
            if (out_valid) begin
                chk("sb_has_entry", 128'(sb.size() > 0), 128'(1));
                if (sb.size() > 0) begin
                    e = sb[0];
                    chk("out_lane_mask", 128'(out_lane_mask), 128'(e.mask));
                    chk("out_prod", out_prod, e.prod);
                    chk("out_row_id", out_row_id, e.id);
                    chk("out_row_last", 128'(out_row_last), 128'(e.last));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        pop_cnt++;
                        if (first_pop < 0) first_pop = cyc;
                        last_pop = cyc;
                    end
                end
                if (out_ready) mdl_beats++;
                else           mdl_stall++;
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_lane_mask, in_val, in_vec, in_row_id, in_row_last));
        end else begin
            mdl_beats = 0;
            mdl_stall = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [C-1:0] m, input logic [C*W-1:0] a,
                          input logic [C*W-1:0] b, input logic [C*W-1:0] id, input logic [C-1:0] l);
        in_valid     = v;
        in_lane_mask = m;
        in_val       = a;
        in_vec       = b;
        in_row_id    = id;
        in_row_last  = l;
    endtask

    function automatic logic [C*W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) cycle();
        chk("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        // Test 1: reset for two cycles, then every output must read zero.
        rst       = 1'b1;
        out_ready = 1'b0;
        set_in(1'b0, '0, '0, '0, '0, '0);
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_mask", 128'(out_lane_mask), 128'(0));
        chk("rst_out_prod", out_prod, 128'(0));
        chk("rst_out_row_id", out_row_id, 128'(0));
        chk("rst_out_row_last", 128'(out_row_last), 128'(0));

        // Test 2: a single bundle appears only at t0+5.
        out_ready = 1'b1;
        set_in(1'b1, 4'hF, {32'd5, 32'd4, 32'd3, 32'd2}, {4{32'd10}},
               {32'd103, 32'd102, 32'd101, 32'd100}, 4'b1000);
        cycle();
        in_valid = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            chk($sformatf("latency_j%0d", j), 128'(out_valid), 128'(j == 5));
            if (j == 5) chk("t2_prod", out_prod, {32'd50, 32'd40, 32'd30, 32'd20});
            cycle();
        end
        drain();

        // Test 3: 20 bundles back to back with out_ready held high.
        pop_cnt   = 0;
        first_pop = -1;
        last_pop  = -1;
        for (int k = 0; k < 20; k++) begin
            set_in(1'b1, 4'hF, rnd128(), rnd128(), {4{32'(k)}}, 4'(k));
            cycle();
        end
        drain();
        chk("b2b_count", 128'(pop_cnt), 128'(20));
        chk("b2b_no_gaps", 128'(last_pop - first_pop), 128'(19));

        // Test 4: fill the pipe with out_ready low, stall 8 cycles, release.
        out_ready = 1'b0;
        pop_cnt   = 0;
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 4'hF, rnd128(), rnd128(), {4{32'(100 + k)}}, 4'hF);
            cycle();
        end
        chk("full_out_valid", 128'(out_valid), 128'(1));
        set_in(1'b1, 4'hA, rnd128(), rnd128(), {4{32'd999}}, 4'hF);
        for (int k = 0; k < 8; k++) begin
            chk("stall_in_ready", 128'(in_ready), 128'(0));
            chk("stall_row_id", out_row_id, {4{32'd100}});
            cycle();
        end
        chk("stall_sb_size", 128'(sb.size()), 128'(5));
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        drain();
        chk("stall_delivered", 128'(pop_cnt), 128'(6));

        // Test 5: truncation, a partial mask, and an empty-mask bundle.
        set_in(1'b1, 4'b0101, {4{32'hFFFF_FFFF}}, {4{32'd2}}, {32'd7, 32'd6, 32'd5, 32'd4}, 4'hF);
        cycle();
        set_in(1'b1, 4'b0000, rnd128(), rnd128(), {32'd11, 32'd12, 32'd13, 32'd14}, 4'hF);
        cycle();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) cycle();
        chk("trunc_prod", out_prod, {32'd0, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFE});
        chk("trunc_row_last", 128'(out_row_last), 128'(4'b0101));
        drain();

        // Test 6: reset with 3 bundles in flight, then a random run.
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 4'hF, rnd128(), rnd128(), rnd128(), 4'h3);
            cycle();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_out_prod", out_prod, 128'(0));
        for (int j = 0; j < 6; j++) cycle();
        chk("midrst_stays_idle", 128'(out_valid), 128'(0));
`ifdef SPM_MUL_PIPE_PERF_EN
        chk("perf_beats_clr", 128'(perf_beats), 128'(0));
        chk("perf_stall_clr", 128'(perf_stall), 128'(0));
`endif
        pop_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            set_in(1'($urandom_range(0, 1)), 4'($urandom), rnd128(), rnd128(), rnd128(), 4'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        drain();
`ifdef SPM_MUL_PIPE_PERF_EN
        chk("perf_beats_vs_sb", 128'(perf_beats), 128'(pop_cnt));
        chk("perf_beats_model", 128'(perf_beats), 128'(mdl_beats));
        chk("perf_stall_model", 128'(perf_stall), 128'(mdl_stall));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Stops the run if the sequence above ever hangs.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
